// File: rtl/fir_pkg.sv
// Shared constants for the FIR result path: result width, CSR word addresses
// and register bit positions.
package fir_pkg;

    localparam int FIR_RES_W = 18;

    localparam logic [3:0] ADDR_DATA   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_CTRL   = 4'd2;
    localparam logic [3:0] ADDR_THRESH = 4'd3;
    localparam logic [3:0] ADDR_CLEAR  = 4'd4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_UDF       = 3;
    localparam int ST_IRQ       = 4;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_CAP_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int CLR_OVF = 2;
    localparam int CLR_UDF = 3;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with a combinational head output. A pop on empty is ignored;
// a push on full is accepted only when a pop frees a slot in the same cycle.
module fir_sync_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic [PTR_W:0]    o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_ONE;
        end
    end

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/fir_result_fifo.sv
// Captures FIR results into a FIFO and exposes them over an Avalon-MM style CSR
// window with status, sticky OVF/UDF flags and a level/overflow interrupt.
module fir_result_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_RES_W,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_res_valid,
    input  logic [DATA_W-1:0] i_res_data,
    input  logic              i_chipselect,
    input  logic              i_write,
    input  logic              i_read,
    input  logic [3:0]        i_address,
    input  logic [31:0]       i_writedata,
    output logic [31:0]       o_readdata,
    output logic              o_irq
);

    logic              r_cap_en;
    logic              r_irq_en;
    logic [PTR_W:0]    r_thresh;
    logic              r_ovf;
    logic              r_udf;
    logic              r_irq;
    logic [31:0]       r_readdata;

    logic              w_rd;
    logic              w_wr;
    logic              w_pop;
    logic              w_flush;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic              w_clr_ovf;
    logic              w_clr_udf;
    logic              w_lvl_hit;
    logic [DATA_W-1:0] w_head;
    logic [PTR_W:0]    w_count;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_status;
    logic [31:0]       w_rd_mux;

    assign w_rd    = i_chipselect & i_read;
    assign w_wr    = i_chipselect & i_write;
    assign w_pop   = w_rd & (i_address == ADDR_DATA);
    assign w_flush = w_wr & (i_address == ADDR_CTRL) & i_writedata[CTRL_FLUSH];
    assign w_push  = i_res_valid & r_cap_en & ~w_flush;

    // A full FIFO is never empty, so any DATA read in that cycle frees a slot.
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_udf_set = w_pop & w_empty;
    assign w_clr_ovf = w_wr & (i_address == ADDR_CLEAR) & i_writedata[CLR_OVF];
    assign w_clr_udf = w_wr & (i_address == ADDR_CLEAR) & i_writedata[CLR_UDF];
    assign w_lvl_hit = (r_thresh != '0) & (w_count >= r_thresh);

    fir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (i_res_data),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_status                            = '0;
        w_status[ST_EMPTY]                  = w_empty;
        w_status[ST_FULL]                   = w_full;
        w_status[ST_OVF]                    = r_ovf;
        w_status[ST_UDF]                    = r_udf;
        w_status[ST_IRQ]                    = r_irq;
        w_status[ST_COUNT_LSB +: PTR_W + 1] = w_count;
    end

    always_comb begin
        w_rd_mux = '0;
        case (i_address)
            ADDR_DATA:   if (!w_empty) w_rd_mux[DATA_W-1:0] = w_head;
            ADDR_STATUS: w_rd_mux = w_status;
            ADDR_CTRL: begin
                w_rd_mux[CTRL_CAP_EN] = r_cap_en;
                w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
            end
            ADDR_THRESH: w_rd_mux[PTR_W:0] = r_thresh;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_en   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_thresh   <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_wr && i_address == ADDR_CTRL) begin
                r_cap_en <= i_writedata[CTRL_CAP_EN];
                r_irq_en <= i_writedata[CTRL_IRQ_EN];
            end
            if (w_wr && i_address == ADDR_THRESH) r_thresh <= i_writedata[PTR_W:0];
            // Set has priority over a W1C clear in the same cycle.
            r_ovf <= w_ovf_set | (r_ovf & ~w_clr_ovf);
            r_udf <= w_udf_set | (r_udf & ~w_clr_udf);
            r_irq <= r_irq_en & (w_lvl_hit | r_ovf);
            if (w_rd) r_readdata <= w_rd_mux;
        end
    end

    assign o_readdata = r_readdata;
    assign o_irq      = r_irq;

endmodule

// File: tb/tb_fir_result_fifo.sv
// Self-checking bench for fir_result_fifo: directed plan plus random traffic
// compared every cycle against a queue-based reference model.
module tb_fir_result_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_res_valid = 1'b0;
    logic [17:0] i_res_data = '0;
    logic        i_chipselect = 1'b0;
    logic        i_write = 1'b0;
    logic        i_read = 1'b0;
    logic [3:0]  i_address = '0;
    logic [31:0] i_writedata = '0;
    logic [31:0] o_readdata;
    logic        o_irq;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_q[$];
    bit          m_ovf, m_udf, m_cap, m_ien, m_irq;
    int          m_thr;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    fir_result_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_res_valid  (i_res_valid),
        .i_res_data   (i_res_data),
        .i_chipselect (i_chipselect),
        .i_write      (i_write),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_writedata  (i_writedata),
        .o_readdata   (o_readdata),
        .o_irq        (o_irq)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int sz = m_q.size();
        return 32'(sz == 0) + 32'(sz == DEPTH) * 2 + 32'(m_ovf) * 4 + 32'(m_udf) * 8
             + 32'(m_irq) * 16 + 32'(sz) * 256;
    endfunction

    // Advance the model by one clock edge given the inputs being applied now.
    task automatic model_step();
        bit rd = i_chipselect && i_read;
        bit wr = i_chipselect && i_write;
        int sz = m_q.size();
        bit is_data  = (i_address == 4'd0);
        bit flush    = wr && i_address == 4'd2 && i_writedata[2];
        bit pop_ok   = rd && is_data && sz > 0;
        bit udf_set  = rd && is_data && sz == 0;
        bit push_req = i_res_valid && m_cap;
        bit push_ok  = push_req && !flush && !(sz == DEPTH && !pop_ok);
        bit ovf_set  = push_req && !flush && sz == DEPTH && !pop_ok;
        bit new_irq  = m_ien && ((m_thr != 0 && sz >= m_thr) || m_ovf);
        if (rd) begin
            case (i_address)
                4'd0: m_rdata = (sz == 0) ? 32'h0 : 32'(m_q[0]);
                4'd1: m_rdata = model_status();
                4'd2: m_rdata = 32'(m_cap) + 32'(m_ien) * 2;
                4'd3: m_rdata = 32'(m_thr);
                default: m_rdata = 32'h0;
            endcase
        end
        if (flush) m_q.delete();
        else begin
            if (pop_ok)  void'(m_q.pop_front());
            if (push_ok) m_q.push_back(int'(i_res_data));
        end
        m_ovf = ovf_set || (m_ovf && !(wr && i_address == 4'd4 && i_writedata[2]));
        m_udf = udf_set || (m_udf && !(wr && i_address == 4'd4 && i_writedata[3]));
        if (wr && i_address == 4'd2) begin
            m_cap = i_writedata[0];
            m_ien = i_writedata[1];
        end
        if (wr && i_address == 4'd3) m_thr = int'(i_writedata[4:0]);
        m_irq = new_irq;
    endtask

    task automatic bus_cycle(input string tag, input bit rv, input logic [17:0] rdat,
                             input bit cs, input bit wr, input bit rd,
                             input logic [3:0] addr, input logic [31:0] wd);
        @(negedge clk);
        i_res_valid  = rv;
        i_res_data   = rdat;
        i_chipselect = cs;
        i_write      = wr;
        i_read       = rd;
        i_address    = addr;
        i_writedata  = wd;
        model_step();
        @(posedge clk);
        #1;
        check_val({tag, "/rdata"}, o_readdata, m_rdata);
        check_val({tag, "/irq"}, 32'(o_irq), 32'(m_irq));
        if (cs && (wr || rd) || rv)
            $display("[%0t] %s rv=%0b d=%05h wr=%0b rd=%0b a=%0d wd=%08h -> rdata=%08h irq=%0b",
                     $time, tag, rv, rdat, cs & wr, cs & rd, addr, wd, o_readdata, o_irq);
    endtask

    task automatic idle(input string tag);
        bus_cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    endtask
    task automatic push(input string tag, input logic [17:0] d);
        bus_cycle(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    endtask
    task automatic rd_reg(input string tag, input logic [3:0] a);
        bus_cycle(tag, 1'b0, '0, 1'b1, 1'b0, 1'b1, a, 32'h0);
    endtask
    task automatic wr_reg(input string tag, input logic [3:0] a, input logic [31:0] wd);
        bus_cycle(tag, 1'b0, '0, 1'b1, 1'b1, 1'b0, a, wd);
    endtask

    initial begin
        logic [17:0] d;
        logic [31:0] wd;
        int r;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset/rdata", o_readdata, 32'h0);
        check_val("reset/irq", 32'(o_irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        rd_reg("tp1_status", 4'd1);
        check_val("tp1_status_lit", o_readdata, 32'h0000_0001);

        wr_reg("tp2_ctrl", 4'd2, 32'h1);
        push("tp2_push", 18'h3FFFF);
        push("tp2_push", 18'h00001);
        push("tp2_push", 18'h12345);
        rd_reg("tp2_status", 4'd1);
        check_val("tp2_count_lit", o_readdata, 32'h0000_0300);
        rd_reg("tp2_data0", 4'd0);
        check_val("tp2_data0_lit", o_readdata, 32'h0003_FFFF);
        rd_reg("tp2_data1", 4'd0);
        check_val("tp2_data1_lit", o_readdata, 32'h0000_0001);
        rd_reg("tp2_data2", 4'd0);
        check_val("tp2_data2_lit", o_readdata, 32'h0001_2345);
        rd_reg("tp2_empty", 4'd1);
        check_val("tp2_empty_lit", o_readdata, 32'h0000_0001);

        for (int i = 0; i < DEPTH; i++) push("tp3_fill", 18'(i * 4099 + 7));
        push("tp3_ovf_push", 18'h2AAAA);
        rd_reg("tp3_status", 4'd1);
        check_val("tp3_full_ovf_lit", o_readdata, 32'h0000_1006);
        for (int i = 0; i < DEPTH; i++) begin
            rd_reg("tp3_drain", 4'd0);
            check_val("tp3_order_lit", o_readdata, 32'(18'(i * 4099 + 7)));
        end
        wr_reg("tp3_clear", 4'd4, 32'h4);
        rd_reg("tp3_status2", 4'd1);
        check_val("tp3_ovf_clr_lit", o_readdata, 32'h0000_0001);

        bus_cycle("tp4_udf_push", 1'b1, 18'h00055, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0);
        check_val("tp4_udf_rdata_lit", o_readdata, 32'h0);
        rd_reg("tp4_status", 4'd1);
        check_val("tp4_status_lit", o_readdata, 32'h0000_0108);
        rd_reg("tp4_data", 4'd0);
        check_val("tp4_data_lit", o_readdata, 32'h0000_0055);
        wr_reg("tp4_clear", 4'd4, 32'h8);

        wr_reg("tp5_thresh", 4'd3, 32'h4);
        wr_reg("tp5_ctrl", 4'd2, 32'h3);
        for (int i = 0; i < 4; i++) push("tp5_push", 18'(i + 1));
        check_val("tp5_irq_lag_lit", 32'(o_irq), 32'h0);
        idle("tp5_idle");
        check_val("tp5_irq_rise_lit", 32'(o_irq), 32'h1);
        rd_reg("tp5_pop", 4'd0);
        idle("tp5_idle2");
        check_val("tp5_irq_fall_lit", 32'(o_irq), 32'h0);

        wr_reg("tp6_ctrl", 4'd2, 32'h1);
        for (int i = 0; i < 3; i++) rd_reg("tp6_drain", 4'd0);
        for (int i = 0; i < 5; i++) push("tp6_push", 18'(i + 100));
        bus_cycle("tp6_flush", 1'b1, 18'h1_1111, 1'b1, 1'b1, 1'b0, 4'd2, 32'h5);
        rd_reg("tp6_status", 4'd1);
        check_val("tp6_flush_lit", o_readdata, 32'h0000_0001);
        rd_reg("tp6_ctrl_rb", 4'd2);
        check_val("tp6_ctrl_lit", o_readdata, 32'h0000_0001);

        for (int n = 0; n < 400; n++) begin
            d = 18'($urandom);
            r = int'($urandom_range(0, 99));
            wd = $urandom;
            if (r < 30) begin
                idle("rnd_idle");
            end else if (r < 55) begin
                bus_cycle("rnd_data", $urandom_range(0, 1) == 1, d, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0);
            end else if (r < 65) begin
                bus_cycle("rnd_stat", $urandom_range(0, 1) == 1, d, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0);
            end else if (r < 72) begin
                wd[0] = ($urandom_range(0, 4) != 0);
                wd[2] = ($urandom_range(0, 9) == 0);
                bus_cycle("rnd_ctrl", $urandom_range(0, 1) == 1, d, 1'b1, 1'b1,
                          $urandom_range(0, 1) == 1, 4'd2, wd);
            end else if (r < 76) begin
                bus_cycle("rnd_thr", $urandom_range(0, 1) == 1, d, 1'b1, 1'b1,
                          $urandom_range(0, 1) == 1, 4'd3, wd);
            end else if (r < 80) begin
                bus_cycle("rnd_clr", $urandom_range(0, 1) == 1, d, 1'b1, 1'b1, 1'b0, 4'd4, wd);
            end else if (r < 84) begin
                bus_cycle("rnd_any", 1'b0, d, 1'b1, $urandom_range(0, 1) == 1, 1'b1,
                          4'($urandom_range(2, 15)), wd);
            end else begin
                push("rnd_push", d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
